serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage reused over WIDTH cycles,
// LSB first, with a carry flip-flop between cycles and a start/busy/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             c_in,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             sum_bit;
   logic             carry_next;
   logic [WIDTH-1:0] s_shift;

   always_comb begin
      sum_bit    = op_a[0] ^ op_b[0] ^ carry;
      carry_next = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
   end

   // The sum bit enters from the MSB side so s is LSB-aligned after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_s_narrow
         assign s_shift = sum_bit;
      end else begin : g_s_wide
         assign s_shift = {sum_bit, s[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtraction is x + ~y + ~borrow; the final carry then means "no borrow".
                  op_a  <= x;
                  op_b  <= sub ? ~y : y;
                  carry <= sub ^ c_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               s     <= s_shift;
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               carry <= carry_next;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  c_out <= carry_next;
                  ovf   <= carry ^ carry_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8, 1 and 16 instances checked against an
// arithmetic reference model (integer sums, unsigned and signed ranges).
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   logic        st8 = 0, sb8 = 0, ci8 = 0;
   logic [7:0]  x8 = '0, y8 = '0;
   logic        busy8, done8, co8, ov8;
   logic [7:0]  s8;

   logic        st1 = 0, sb1 = 0, ci1 = 0;
   logic [0:0]  x1 = '0, y1 = '0;
   logic        busy1, done1, co1, ov1;
   logic [0:0]  s1;

   logic        st16 = 0, sb16 = 0, ci16 = 0;
   logic [15:0] x16 = '0, y16 = '0;
   logic        busy16, done16, co16, ov16;
   logic [15:0] s16;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8), .c_in(ci8), .x(x8), .y(y8),
      .busy(busy8), .done(done8), .s(s8), .c_out(co8), .ovf(ov8));
   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1), .c_in(ci1), .x(x1), .y(y1),
      .busy(busy1), .done(done1), .s(s1), .c_out(co1), .ovf(ov1));
   serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(st16), .sub(sb16), .c_in(ci16), .x(x16), .y(y16),
      .busy(busy16), .done(done16), .s(s16), .c_out(co16), .ovf(ov16));

   int sel = 8;
   wire        sel_busy = (sel == 1) ? busy1 : (sel == 16) ? busy16 : busy8;
   wire        sel_done = (sel == 1) ? done1 : (sel == 16) ? done16 : done8;
   wire        sel_co   = (sel == 1) ? co1   : (sel == 16) ? co16   : co8;
   wire        sel_ov   = (sel == 1) ? ov1   : (sel == 16) ? ov16   : ov8;
   wire [15:0] sel_s    = (sel == 1) ? {15'b0, s1} : (sel == 16) ? s16 : {8'b0, s8};

   // Reference: plain integer arithmetic, unsigned carry/borrow and signed range test.
   task automatic model(input int w, input bit is_sub, input bit ci, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] es, output bit ec,
                        output bit eo);
      longint m, ua, ub, sa, sbv, t, r;
      m  = longint'(1) << w;
      ua = longint'(a) % m;
      ub = longint'(b) % m;
      sa  = (ua >= m / 2) ? ua - m : ua;
      sbv = (ub >= m / 2) ? ub - m : ub;
      if (!is_sub) begin
         t  = ua + ub + longint'(ci);
         ec = (t >= m);
         r  = sa + sbv + longint'(ci);
      end else begin
         t  = ua - ub - longint'(ci);
         ec = (t >= 0);
         r  = sa - sbv - longint'(ci);
      end
      es = 16'((t + m) % m);
      eo = (r < -(m / 2)) || (r > m / 2 - 1);
   endtask

   task automatic drive(input int w, input bit st, input bit is_sub, input bit ci,
                        input logic [15:0] a, input logic [15:0] b);
      case (w)
         1:  begin st1 = st;  sb1 = is_sub;  ci1 = ci;  x1 = a[0:0]; y1 = b[0:0]; end
         16: begin st16 = st; sb16 = is_sub; ci16 = ci; x16 = a;     y16 = b;     end
         default: begin st8 = st; sb8 = is_sub; ci8 = ci; x8 = a[7:0]; y8 = b[7:0]; end
      endcase
   endtask

   // One operation from IDLE; inputs are scrambled after the start edge.
   task automatic do_op(input int w, input bit is_sub, input bit ci, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] rs, output bit rc,
                        output bit ro, output int lat, output int bcnt, output bit bsy_at_done);
      sel = w;
      @(negedge clk);
      drive(w, 1'b1, is_sub, ci, a, b);
      @(posedge clk); #1;
      drive(w, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      lat = -1;
      bcnt = 0;
      for (int k = 1; k <= w + 10; k++) begin
         if (sel_busy) bcnt++;
         @(posedge clk); #1;
         if (sel_done) begin
            lat = k;
            break;
         end
      end
      rs = sel_s;
      rc = sel_co;
      ro = sel_ov;
      bsy_at_done = sel_busy;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({busy8, done8, s8, co8, ov8} !== 12'h0) begin
         n_fail++; $display("FAIL reset_w8: got %h expected 0", {busy8, done8, s8, co8, ov8});
      end
      n_checks++;
      if ({busy1, done1, s1, co1, ov1} !== 5'h0) begin
         n_fail++; $display("FAIL reset_w1: got %h expected 0", {busy1, done1, s1, co1, ov1});
      end
      n_checks++;
      if ({busy16, done16, s16, co16, ov16} !== 20'h0) begin
         n_fail++; $display("FAIL reset_w16: got %h expected 0", {busy16, done16, s16, co16, ov16});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_op(input string name, input int w, input bit is_sub, input bit ci,
                           input logic [15:0] a, input logic [15:0] b);
      logic [15:0] rs, es;
      bit rc, ro, ec, eo, bd;
      int lat, bcnt;
      do_op(w, is_sub, ci, a, b, rs, rc, ro, lat, bcnt, bd);
      model(w, is_sub, ci, a, b, es, ec, eo);
      n_checks++;
      if (lat != w) begin
         n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, w);
      end
      n_checks++;
      if (bcnt != w || bd !== 1'b0) begin
         n_fail++; $display("FAIL %s_busy: got %0d cycles (at done %b) expected %0d (0)", name, bcnt, bd, w);
      end
      n_checks++;
      if (rs !== es || rc !== ec || ro !== eo) begin
         n_fail++;
         $display("FAIL %s_result: got s=%h c=%b v=%b expected s=%h c=%b v=%b", name, rs, rc, ro, es, ec, eo);
      end
   endtask

   task automatic test_add();
      logic [15:0] hold;
      check_op("add_5a_3c", 8, 0, 0, 16'h5A, 16'h3C);
      n_checks++;
      if (s8 !== 8'h96 || co8 !== 1'b0 || ov8 !== 1'b1) begin
         n_fail++; $display("FAIL add_5a_3c_const: got s=%h c=%b v=%b expected s=96 c=0 v=1", s8, co8, ov8);
      end
      hold = {8'b0, s8};
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({8'b0, s8} !== hold || done8 !== 1'b0 || busy8 !== 1'b0) begin
         n_fail++; $display("FAIL idle_hold: got s=%h done=%b busy=%b expected s=96 done=0 busy=0", s8, done8, busy8);
      end
      check_op("add_ff_01", 8, 0, 0, 16'hFF, 16'h01);
      check_op("add_cin", 8, 0, 1, 16'h00, 16'h00);
   endtask

   task automatic test_sub();
      check_op("sub_10_20", 8, 1, 0, 16'h10, 16'h20);
      check_op("sub_80_01", 8, 1, 0, 16'h80, 16'h01);
      check_op("sub_borrow_in", 8, 1, 1, 16'h00, 16'h00);
      n_checks++;
      if (s8 !== 8'hFF || co8 !== 1'b0) begin
         n_fail++; $display("FAIL sub_borrow_in_const: got s=%h c=%b expected s=ff c=0", s8, co8);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] es;
      bit ec, eo;
      int t;
      sel = 8;
      @(negedge clk);
      drive(8, 1'b1, 1'b0, 1'b0, 16'h5A, 16'h3C);
      @(posedge clk); #1;
      t = 0;
      for (int k = 0; k < 30; k++) begin
         drive(8, 1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         @(posedge clk); #1;
         t++;
         if (done8) break;
      end
      model(8, 0, 0, 16'h5A, 16'h3C, es, ec, eo);
      n_checks++;
      if (t != 8 || {8'b0, s8} !== es || co8 !== ec || ov8 !== eo) begin
         n_fail++; $display("FAIL b2b_first: got t=%0d s=%h c=%b v=%b expected t=8 s=%h c=%b v=%b", t, s8, co8, ov8, es, ec, eo);
      end
      drive(8, 1'b1, 1'b1, 1'b0, 16'h80, 16'h01);
      t = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         t++;
         if (done8) break;
         drive(8, 1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      end
      st8 = 1'b0;
      model(8, 1, 0, 16'h80, 16'h01, es, ec, eo);
      n_checks++;
      if (t != 9 || {8'b0, s8} !== es || co8 !== ec || ov8 !== eo) begin
         n_fail++; $display("FAIL b2b_second: got t=%0d s=%h c=%b v=%b expected t=9 s=%h c=%b v=%b", t, s8, co8, ov8, es, ec, eo);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
         n_fail++; $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done8, busy8);
      end
   endtask

   task automatic test_reset_mid_run();
      bit saw_done;
      sel = 8;
      @(negedge clk);
      drive(8, 1'b1, 1'b0, 1'b0, 16'h5A, 16'h3C);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, 1'b0, 16'h00, 16'h00);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy8, done8, s8, co8, ov8} !== 12'h0) begin
         n_fail++; $display("FAIL midrun_reset_outputs: got %h expected 0", {busy8, done8, s8, co8, ov8});
      end
      saw_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (done8) saw_done = 1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (done8 || busy8) saw_done = 1;
      end
      n_checks++;
      if (saw_done) begin
         n_fail++; $display("FAIL midrun_no_done: got activity=1 expected 0");
      end
      check_op("after_reset", 8, 0, 0, 16'h5A, 16'h3C);
   endtask

   task automatic test_random(input int w, input int n);
      logic [15:0] rs, es, a, b;
      bit rc, ro, ec, eo, ci, bd;
      int lat, bcnt, bad;
      for (int mode = 0; mode < 2; mode++) begin
         bad = 0;
         for (int i = 0; i < n; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom_range(0, 1));
            do_op(w, 1'(mode), ci, a, b, rs, rc, ro, lat, bcnt, bd);
            model(w, 1'(mode), ci, a, b, es, ec, eo);
            n_checks++;
            if (lat != w || rs !== es || rc !== ec || ro !== eo) begin
               n_fail++;
               if (bad < 10)
                  $display("FAIL rand_w%0d_m%0d: a=%h b=%h ci=%b got lat=%0d s=%h c=%b v=%b expected lat=%0d s=%h c=%b v=%b",
                           w, mode, a, b, ci, lat, rs, rc, ro, w, es, ec, eo);
               bad++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_reset_mid_run();
      test_random(8, 200);
      test_random(1, 1000);
      test_random(16, 1000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
